// File: rtl/dccm_pkg.sv
// Shared types and widths for the DCCM arbiter
// and the DFFRAM data memory behind it.
package dccm_pkg;

  localparam int DccmAw = 12;
  localparam int DccmDw = 32;

  typedef struct packed {
    logic              we;
    logic              lock;
    logic [DccmAw-1:0] addr;
    logic [DccmDw-1:0] wdata;
    logic [DccmDw/8-1:0] be;
  } dccm_req_t;

  typedef struct packed {
    logic              rvalid;
    logic [DccmDw-1:0] rdata;
  } dccm_rsp_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/rr_arb_fixed.sv
// Combinational round-robin picker: scans from
// ptr+1 upward with wrap and returns one-hot and index.
module rr_arb_fixed #(
  parameter int N    = 2,
  parameter int IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx
);

  logic found;
  int   c;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = IdxW'(c);
      end
    end
  end

endmodule

// File: rtl/dccm_arbiter.sv
// Round-robin arbiter with bounded lock in front
// of a single-port DFFRAM (1-cycle read latency).
module dccm_arbiter
  import dccm_pkg::*;
#(
  parameter int NumReq  = 2,
  parameter int Aw      = DccmAw,
  parameter int Dw      = DccmDw,
  parameter int LockMax = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumReq-1:0]          req_i,
  input  logic [NumReq-1:0]          lock_i,
  input  logic [NumReq-1:0]          we_i,
  input  logic [NumReq-1:0][Aw-1:0]  addr_i,
  input  logic [NumReq-1:0][Dw-1:0]  wdata_i,
  input  logic [NumReq-1:0][Dw/8-1:0] be_i,
  output logic [NumReq-1:0]          gnt_o,
  output logic [NumReq-1:0]          rvalid_o,
  output logic [Dw-1:0]              rdata_o,
  output logic                       lock_timeout_o,
  output logic                       mem_en_o,
  output logic [Dw/8-1:0]            mem_we_o,
  output logic [Aw-1:0]              mem_addr_o,
  output logic [Dw-1:0]              mem_wdata_o,
  input  logic [Dw-1:0]              mem_rdata_i
);

  localparam int IdxW = $clog2(NumReq);
  localparam int CntW = $clog2(LockMax + 1);

  lock_state_e     state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tmo_q, tmo_d;
  logic [IdxW-1:0] ptr_q;
  logic            rsp_valid_q;
  logic [IdxW-1:0] rsp_id_q;

  logic [NumReq-1:0] rr_gnt;
  logic [IdxW-1:0]   rr_idx;
  logic              lock_hit;
  logic              gnt_any;
  logic [IdxW-1:0]   gnt_idx;

  rr_arb_fixed #(
    .N    (NumReq),
    .IdxW (IdxW)
  ) u_rr (
    .req (req_i),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  assign lock_hit = (state_q == LOCKED) && req_i[owner_q];
  assign gnt_idx  = lock_hit ? owner_q : rr_idx;
  assign gnt_any  = !rst_i && (lock_hit || (|rr_gnt));

  always_comb begin
    gnt_o = '0;
    if (gnt_any) gnt_o[gnt_idx] = 1'b1;
  end

  assign mem_en_o    = gnt_any;
  assign mem_addr_o  = addr_i[gnt_idx];
  assign mem_wdata_o = wdata_i[gnt_idx];
  assign mem_we_o    = (gnt_any && we_i[gnt_idx])
                     ? be_i[gnt_idx] : '0;

  always_comb begin
    rvalid_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      rvalid_o[i] = !rst_i && rsp_valid_q
                  && (rsp_id_q == IdxW'(i));
    end
  end

  assign rdata_o        = mem_rdata_i;
  assign lock_timeout_o = tmo_q && !rst_i;

  // A fresh lock is refused right after a timeout so
  // the others get one round-robin turn.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      UNLOCKED: begin
        if (gnt_any && lock_i[gnt_idx] && !tmo_q) begin
          state_d = LOCKED;
          owner_d = gnt_idx;
          cnt_d   = CntW'(1);
        end
      end
      LOCKED: begin
        if (lock_hit) begin
          if (lock_i[owner_q]
              && (cnt_q < CntW'(LockMax - 1))) begin
            cnt_d = cnt_q + CntW'(1);
          end else begin
            state_d = UNLOCKED;
            cnt_d   = '0;
            tmo_d   = lock_i[owner_q];
          end
        end else begin
          state_d = UNLOCKED;
          cnt_d   = '0;
          if (gnt_any && lock_i[gnt_idx]) begin
            state_d = LOCKED;
            owner_d = gnt_idx;
            cnt_d   = CntW'(1);
          end
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= IdxW'(NumReq - 1);
      state_q     <= UNLOCKED;
      owner_q     <= '0;
      cnt_q       <= '0;
      tmo_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      if (gnt_any) ptr_q <= gnt_idx;
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      rsp_valid_q <= gnt_any && !we_i[gnt_idx];
      rsp_id_q    <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_dccm_arbiter.sv
// Directed bench for dccm_arbiter with a small
// behavioural DFFRAM model behind it.
module tb_dccm_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req, lock, we;
  logic [1:0][11:0] addr;
  logic [1:0][31:0] wdata;
  logic [1:0][3:0]  be;
  logic [1:0]       gnt, rvalid;
  logic [31:0]      rdata;
  logic             tmo;
  logic             mem_en;
  logic [3:0]       mem_we;
  logic [11:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  logic [31:0] mem [0:4095];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dccm_arbiter #(
    .NumReq  (2),
    .Aw      (12),
    .Dw      (32),
    .LockMax (8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .lock_i         (lock),
    .we_i           (we),
    .addr_i         (addr),
    .wdata_i        (wdata),
    .be_i           (be),
    .gnt_o          (gnt),
    .rvalid_o       (rvalid),
    .rdata_o        (rdata),
    .lock_timeout_o (tmo),
    .mem_en_o       (mem_en),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = '0; lock = '0; we = '0;
    addr = '0; wdata = '0; be = '0;
  endtask

  task automatic wr0(input logic [11:0] a,
                     input logic [31:0] d,
                     input logic [3:0] m);
    req = 2'b01; we = 2'b01; lock = '0;
    addr[0] = a; wdata[0] = d; be[0] = m;
  endtask

  task automatic rd0(input logic [11:0] a);
    req = 2'b01; we = '0; lock = '0;
    addr[0] = a; be[0] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [1:0]  exp_g, prev_g;
  logic [31:0] prev_d;

  initial begin
    rst = 1'b1;
    idle();
    req = 2'b11;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_en", 32'(mem_en), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_tmo", 32'(tmo), 32'h0);
    tick();
    rst = 1'b0;
    idle();

    wr0(12'h010, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("t1_wr_gnt", 32'(gnt), 32'h1);
    chk("t1_wr_we", 32'(mem_we), 32'hF);
    chk("t1_wr_addr", 32'(mem_addr), 32'h010);
    tick();
    rd0(12'h010);
    @(negedge clk);
    chk("t1_rd_gnt", 32'(gnt), 32'h1);
    chk("t1_rd_we", 32'(mem_we), 32'h0);
    chk("t1_wr_norsp", 32'(rvalid), 32'h0);
    tick();
    idle();
    @(negedge clk);
    chk("t1_rvalid", 32'(rvalid), 32'h1);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    chk("t1_idle_en", 32'(mem_en), 32'h0);

    tick();
    wr0(12'h001, 32'hA0A00001, 4'hF);
    tick();
    wr0(12'h002, 32'hB0B00002, 4'hF);
    tick();
    wr0(12'h020, 32'h11223344, 4'hF);
    tick();
    idle();
    do_reset();

    req = 2'b11; we = '0;
    addr[0] = 12'h001; addr[1] = 12'h002;
    prev_g = '0; prev_d = '0;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      chk($sformatf("t2_gnt%0d", k), 32'(gnt), 32'(exp_g));
      chk($sformatf("t2_rv%0d", k), 32'(rvalid), 32'(prev_g));
      if (k > 0) chk($sformatf("t2_rd%0d", k), rdata, prev_d);
      prev_g = exp_g;
      prev_d = (k % 2 == 0) ? 32'hA0A00001 : 32'hB0B00002;
      tick();
    end
    idle();
    @(negedge clk);
    chk("t2_rv_last", 32'(rvalid), 32'h2);
    chk("t2_rd_last", rdata, 32'hB0B00002);

    tick();
    wr0(12'h020, 32'hAAAAAAAA, 4'h4);
    @(negedge clk);
    chk("t3_we", 32'(mem_we), 32'h4);
    tick();
    rd0(12'h020);
    tick();
    idle();
    @(negedge clk);
    chk("t3_rvalid", 32'(rvalid), 32'h1);
    chk("t3_rdata", rdata, 32'h11AA3344);

    tick();
    req = 2'b11; we = '0;
    for (int k = 0; k < 5; k++) begin
      lock = (k < 3) ? 2'b10 : 2'b00;
      @(negedge clk);
      chk($sformatf("t4_gnt%0d", k), 32'(gnt),
          (k < 4) ? 32'h2 : 32'h1);
      chk($sformatf("t4_tmo%0d", k), 32'(tmo), 32'h0);
      tick();
    end
    idle();
    do_reset();

    req = 2'b11; we = '0; lock = 2'b01;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("t5_gnt%0d", k), 32'(gnt),
          (k == 8) ? 32'h2 : 32'h1);
      chk($sformatf("t5_tmo%0d", k), 32'(tmo),
          (k == 8) ? 32'h1 : 32'h0);
      tick();
    end
    idle();

    rd0(12'h001);
    @(negedge clk);
    chk("t6_gnt", 32'(gnt), 32'h1);
    tick();
    rst = 1'b1;
    req = 2'b11; we = '0; lock = '0;
    addr[0] = 12'h001; addr[1] = 12'h002;
    @(negedge clk);
    chk("t6_rst_rv", 32'(rvalid), 32'h0);
    chk("t6_rst_gnt", 32'(gnt), 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_drop_rv", 32'(rvalid), 32'h0);
    chk("t6_first_gnt", 32'(gnt), 32'h1);
    tick();
    idle();
    @(negedge clk);
    chk("t6_rv", 32'(rvalid), 32'h1);
    chk("t6_rd", rdata, 32'hA0A00001);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
